// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: keeps the PC, issues one instruction-memory request
// at a time, captures the response and holds it for decode until accepted.
// Redirects (flush) may arrive in any state; a request already in flight
// when a redirect lands is tracked with 'drop' so its response is discarded.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   next_pc             : PC to advance to when decode accepts an instruction
//   flush, flush_pc     : redirect request and target
//   current_pc(_plus_4) : PC register and PC + 4
//   imem_req_*          : request channel (valid/ready, addr)
//   imem_resp_*         : in-order response (valid, data), no backpressure
//   inst_valid/inst/inst_pc/inst_ready : handoff to decode
//   misaligned_err      : sticky, set by any PC load with value[1:0] != 0
//   fetch_count         : instructions accepted by decode (wraps)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  output logic [31:0] current_pc,
  output logic [31:0] current_pc_plus_4,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misaligned_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  // Datapath control produced by the output decode.
  typedef struct packed {
    logic        pc_ld;
    logic [31:0] pc_val;
    logic        drop_nxt;
    logic        cap;
    logic        cnt_inc;
  } ctl_t;

  state_t state, state_nxt;
  logic   drop;
  ctl_t   ctl;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_REQ;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (imem_req_ready) state_nxt = S_WAIT;
      // A flush or a pending drop turns the response into a discard.
      S_WAIT: if (imem_resp_valid) state_nxt = (flush || drop) ? S_REQ : S_HOLD;
      S_HOLD: if (flush || inst_ready) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // Output / control decode
  always_comb begin
    imem_req_valid = (state == S_REQ);
    inst_valid     = (state == S_HOLD);
    ctl.pc_ld      = 1'b0;
    ctl.pc_val     = flush_pc;
    ctl.drop_nxt   = drop;
    ctl.cap        = 1'b0;
    ctl.cnt_inc    = 1'b0;
    case (state)
      S_REQ: begin
        if (flush) begin
          ctl.pc_ld = 1'b1;
          // Request goes out for the old PC; its response must be thrown away.
          if (imem_req_ready) ctl.drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          // The single outstanding response is consumed here either way.
          ctl.drop_nxt = 1'b0;
          ctl.cap      = !flush && !drop;
          ctl.pc_ld    = flush;
        end else if (flush) begin
          ctl.pc_ld    = 1'b1;
          ctl.drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // Flush wins over acceptance: no count, no next_pc.
        if (flush) begin
          ctl.pc_ld = 1'b1;
        end else if (inst_ready) begin
          ctl.pc_ld   = 1'b1;
          ctl.pc_val  = next_pc;
          ctl.cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      current_pc     <= RESET_PC;
      drop           <= 1'b0;
      inst           <= 32'h0;
      inst_pc        <= 32'h0;
      misaligned_err <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      if (ctl.pc_ld) begin
        current_pc <= {ctl.pc_val[31:2], 2'b00};
        if (|ctl.pc_val[1:0]) misaligned_err <= 1'b1;
      end
      drop <= ctl.drop_nxt;
      if (ctl.cap) begin
        inst    <= imem_resp_data;
        inst_pc <= current_pc;
      end
      if (ctl.cnt_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign current_pc_plus_4 = current_pc + 32'd4;
  assign imem_req_addr     = current_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic [31:0] current_pc, current_pc_plus_4;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        inst_ready;
  logic        misaligned_err;
  logic [31:0] fetch_count;

  int vectors = 0;
  int errs    = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .next_pc(next_pc),
    .current_pc(current_pc), .current_pc_plus_4(current_pc_plus_4),
    .flush(flush), .flush_pc(flush_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .misaligned_err(misaligned_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pc"},      current_pc, 32'h0);
    chk({tag, ".pc4"},     current_pc_plus_4, 32'h4);
    chk({tag, ".ivalid"},  {31'h0, inst_valid}, 32'h0);
    chk({tag, ".inst"},    inst, 32'h0);
    chk({tag, ".inst_pc"}, inst_pc, 32'h0);
    chk({tag, ".mis"},     {31'h0, misaligned_err}, 32'h0);
    chk({tag, ".cnt"},     fetch_count, 32'h0);
    chk({tag, ".rvalid"},  {31'h0, imem_req_valid}, 32'h1);
    chk({tag, ".addr"},    imem_req_addr, 32'h0);
  endtask

  initial begin
    reset = 1'b0; next_pc = 32'h0; flush = 1'b0; flush_pc = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    inst_ready = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    reset = 1'b1;

    // Basic fetch
    imem_req_ready = 1'b1;
    step();
    chk("basic.wait_rvalid", {31'h0, imem_req_valid}, 32'h0);
    chk("basic.wait_ivalid", {31'h0, inst_valid}, 32'h0);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    step();
    imem_resp_valid = 1'b0;
    chk("basic.ivalid", {31'h0, inst_valid}, 32'h1);
    chk("basic.inst", inst, 32'h0050_0093);
    chk("basic.inst_pc", inst_pc, 32'h0);
    next_pc = 32'h4; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("basic.addr", imem_req_addr, 32'h4);
    chk("basic.rvalid", {31'h0, imem_req_valid}, 32'h1);
    chk("basic.cnt", fetch_count, 32'h1);
    chk("basic.ivalid_off", {31'h0, inst_valid}, 32'h0);

    // Request backpressure: address held stable
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.addr", imem_req_addr, 32'h4);
      chk("bp.rvalid", {31'h0, imem_req_valid}, 32'h1);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    step();
    imem_resp_valid = 1'b0; next_pc = 32'h8;
    // Decode backpressure: instruction held, PC unchanged
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp.ivalid", {31'h0, inst_valid}, 32'h1);
      chk("bp.inst", inst, 32'h0000_0013);
      chk("bp.inst_pc", inst_pc, 32'h4);
      chk("bp.pc", current_pc, 32'h4);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("bp.addr_after", imem_req_addr, 32'h8);
    chk("bp.cnt", fetch_count, 32'h2);

    // Flush in REQ without handshake: stay in REQ, new address next cycle
    flush = 1'b1; flush_pc = 32'h10;
    step();
    flush = 1'b0;
    chk("freq.addr", imem_req_addr, 32'h10);
    chk("freq.rvalid", {31'h0, imem_req_valid}, 32'h1);

    // Flush in WAIT, response arrives later and is dropped
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; flush = 1'b1; flush_pc = 32'h80;
    step();
    flush = 1'b0;
    chk("fwait.pc", current_pc, 32'h80);
    chk("fwait.rvalid", {31'h0, imem_req_valid}, 32'h0);
    step();
    chk("fwait.still_wait", {31'h0, imem_req_valid}, 32'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("fwait.ivalid", {31'h0, inst_valid}, 32'h0);
    chk("fwait.rvalid2", {31'h0, imem_req_valid}, 32'h1);
    chk("fwait.addr", imem_req_addr, 32'h80);
    chk("fwait.inst_kept", inst, 32'h0000_0013);

    // Flush together with accept in REQ: old request issued, response dropped
    imem_req_ready = 1'b1; flush = 1'b1; flush_pc = 32'h20;
    step();
    imem_req_ready = 1'b0; flush = 1'b0;
    chk("facc.rvalid", {31'h0, imem_req_valid}, 32'h0);
    chk("facc.pc", current_pc, 32'h20);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    step();
    imem_resp_valid = 1'b0;
    chk("facc.ivalid", {31'h0, inst_valid}, 32'h0);
    chk("facc.addr", imem_req_addr, 32'h20);

    // Flush in HOLD with inst_ready: flush wins
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
    step();
    imem_resp_valid = 1'b0;
    chk("fhold.inst_pc", inst_pc, 32'h20);
    chk("fhold.inst", inst, 32'h2222_2222);
    inst_ready = 1'b1; flush = 1'b1; flush_pc = 32'h40; next_pc = 32'h24;
    step();
    inst_ready = 1'b0; flush = 1'b0;
    chk("fhold.addr", imem_req_addr, 32'h40);
    chk("fhold.cnt", fetch_count, 32'h2);
    chk("fhold.ivalid", {31'h0, inst_valid}, 32'h0);

    // Flush and response in the same WAIT cycle: response discarded
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; flush = 1'b1; flush_pc = 32'h60;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555;
    step();
    flush = 1'b0; imem_resp_valid = 1'b0;
    chk("fresp.ivalid", {31'h0, inst_valid}, 32'h0);
    chk("fresp.addr", imem_req_addr, 32'h60);
    // Next fetch must not be dropped
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_3333;
    step();
    imem_resp_valid = 1'b0;
    chk("fresp.next_ivalid", {31'h0, inst_valid}, 32'h1);
    chk("fresp.next_inst", inst, 32'h3333_3333);
    chk("fresp.next_inst_pc", inst_pc, 32'h60);

    // Misaligned next_pc on accept
    next_pc = 32'h102; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("mis.flag", {31'h0, misaligned_err}, 32'h1);
    chk("mis.addr", imem_req_addr, 32'h100);
    chk("mis.pc4", current_pc_plus_4, 32'h104);
    chk("mis.cnt", fetch_count, 32'h3);
    step();
    chk("mis.sticky", {31'h0, misaligned_err}, 32'h1);

    // Reset during WAIT with response arriving under reset
    flush = 1'b1; flush_pc = 32'h50;
    step();
    flush = 1'b0;
    chk("mrst.addr_pre", imem_req_addr, 32'h50);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    reset = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h4444_4444;
    step();
    imem_resp_valid = 1'b0;
    chk_reset_vals("mrst");
    reset = 1'b1;
    step();
    chk("mrst.addr_post", imem_req_addr, 32'h0);
    chk("mrst.ivalid_post", {31'h0, inst_valid}, 32'h0);
    chk("mrst.mis_post", {31'h0, misaligned_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, the reset: synchronous, active-low (0 = reset).
REQ-004 SHALL have port next_pc, input, 32, the next PC from the next-PC calculation logic.
REQ-005 SHALL have port current_pc, output, 32, the PC register; current_pc_plus_4, output, 32, equal to current_pc + 4 (mod 2^32).
REQ-006 SHALL have port flush, input, 1, the redirect request; flush_pc, input, 32, the redirect target.
REQ-007 SHALL have port imem_req_valid, output, 1; imem_req_addr, output, 32; imem_req_ready, input, 1: instruction-memory request channel.
REQ-008 SHALL have port imem_resp_valid, input, 1; imem_resp_data, input, 32: instruction-memory response, one response per accepted request, in order.
REQ-009 SHALL have port inst_valid, output, 1; inst, output, 32; inst_pc, output, 32; inst_ready, input, 1: instruction handoff to decode.
REQ-010 SHALL have port misaligned_err, output, 1, a sticky flag for an unaligned PC target.
REQ-011 SHALL have port fetch_count, output, 32, the number of instructions accepted by decode.

Function
REQ-012 SHALL implement three states: REQ, WAIT, HOLD.
REQ-013 In REQ: imem_req_valid=1 and imem_req_addr=current_pc; when imem_req_ready=1, go to WAIT; otherwise hold valid and address stable.
REQ-014 In WAIT: imem_req_valid=0; on imem_resp_valid=1 with drop=0, latch inst=imem_resp_data and inst_pc=current_pc, then go to HOLD.
REQ-015 In HOLD: inst_valid=1 and inst/inst_pc stable. On inst_ready=1: current_pc<=next_pc, fetch_count increments by 1, go to REQ.
REQ-016 inst_valid SHALL be 1 only in HOLD, so latency is 2 cycles minimum from REQ to inst_valid (ready and response each in their first cycle).
REQ-017 Any PC load with value[1:0]!=0 SHALL set misaligned_err=1 (sticky until reset) and load {value[31:2],2'b00}.
REQ-018 flush in REQ without the handshake: current_pc<=flush_pc and stay in REQ; the new address is presented next cycle.
REQ-019 flush in REQ with imem_req_ready=1 in the same cycle: the request is issued for the old PC; current_pc<=flush_pc, drop<=1, go to WAIT.
REQ-020 flush in WAIT: current_pc<=flush_pc and drop<=1.
REQ-021 flush in WAIT with imem_resp_valid=1 in the same cycle: the response is discarded and the unit goes to REQ.
REQ-022 In WAIT, a response arriving with drop=1 SHALL be discarded, clear drop and go to REQ; inst_valid stays 0.
REQ-023 flush in HOLD, with or without inst_ready: flush wins; current_pc<=flush_pc, no fetch_count increment, inst_valid drops next cycle, go to REQ.
REQ-024 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 At most one request SHALL be outstanding; imem_req_valid=0 whenever in WAIT or HOLD.

Reset
REQ-026 With reset=0 at a clock edge: state=REQ, current_pc=RESET_PC, drop=0, inst_valid=0, inst=0, inst_pc=0, misaligned_err=0, fetch_count=0.
REQ-027 Reset SHALL take priority over flush and all handshakes; a response outstanding across reset SHALL be ignored if it arrives while reset=0.
REQ-028 After reset deasserts, imem_req_valid=1 with imem_req_addr=RESET_PC on the first cycle.

Verification
REQ-029 Basic fetch: RESET_PC=0, memory always ready, response one cycle after accept, data 32'h00500093, next_pc=current_pc_plus_4, inst_ready=1 -> inst_valid with inst=32'h00500093, inst_pc=0; next request addr=4; fetch_count=1.
REQ-030 Backpressure: imem_req_ready=0 for 3 cycles, then inst_ready=0 for 4 cycles -> addr held at 0 for 3 cycles; inst/inst_pc stable for 4 cycles; no PC change until accept.
REQ-031 Flush in WAIT: req at 0x10 accepted, flush_pc=0x80 next cycle, response 32'hDEADBEEF arrives 2 cycles later -> response dropped, no inst_valid, next request addr=0x80.
REQ-032 Flush with inst_ready in HOLD: inst_pc=0x20, inst_ready=1, flush=1, flush_pc=0x40, next_pc=0x24 -> next addr=0x40, fetch_count unchanged.
REQ-033 Misaligned: next_pc=0x102 on accept -> misaligned_err=1, next addr=0x100, flag remains 1 until reset=0.
REQ-034 Mid-operation reset: reset=0 during WAIT at pc 0x50 with response pending -> response ignored, next request addr=RESET_PC, all outputs at reset values.
